contador_descendente: RTL and testbench



---
 rtl/contador_descendente_if.sv | 24 ++
 rtl/contador_descendente.sv | 68 ++++++
 tb/tb_contador_descendente.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/contador_descendente_if.sv
// Bus bundle for contador_descendente: control, load data and the count/status outputs.
// The master drives the controls and the slave (the counter) drives the status.
interface contador_descendente_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             count;
    logic             load;
    logic [WIDTH-1:0] dato;
    logic             auto_reload;
    logic [WIDTH-1:0] salida;
    logic             activo;
    logic             cero;

    modport master (
        output enable, count, load, dato, auto_reload,
        input  salida, activo, cero
    );

    modport slave (
        input  enable, count, load, dato, auto_reload,
        output salida, activo, cero
    );
endinterface

// File: rtl/contador_descendente.sv
// Loadable down counter/timer with a one-cycle terminal-count pulse and optional auto-reload.
// Optional feature macro CONTADOR_DESCENDENTE_WRAP_EN: a count in IDLE at zero restarts from all-ones.
module contador_descendente #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    contador_descendente_if.slave bus
);

    // The state bits are the status outputs: bit 0 is activo and bit 1 is cero.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] salida;
    logic [WIDTH-1:0] recarga;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, recarga included, has an async reset value.
            state   <= IDLE;
            salida  <= '0;
            recarga <= '0;
        end else if (bus.enable && bus.load) begin
            salida  <= bus.dato;
            recarga <= bus.dato;
            state   <= (bus.dato != '0) ? RUN : DONE;
        end else if (state == DONE) begin
            // DONE always lasts one clock, whatever enable and count are doing.
            if (bus.auto_reload && (recarga != '0)) begin
                salida <= recarga;
                state  <= RUN;
            end else begin
                state <= IDLE;
            end
        end else if (bus.enable && bus.count) begin
            unique case (state)
                RUN: begin
                    salida <= salida - WIDTH'(1);
                    if (salida == WIDTH'(1)) begin
                        state <= DONE;
                    end
                end
                IDLE: begin
`ifdef CONTADOR_DESCENDENTE_WRAP_EN
                    if (salida == '0) begin
                        salida <= '1;
                        state  <= RUN;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.salida = salida;
    assign bus.activo = state[0];
    assign bus.cero   = state[1];

endmodule

// File: tb/tb_contador_descendente.sv
// Directed self-checking bench for contador_descendente (WIDTH=4), hand-computed expectations.
// Builds with or without CONTADOR_DESCENDENTE_WRAP_EN; only the idle-count expectation differs.
module tb_contador_descendente;

    localparam int WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    contador_descendente_if #(.WIDTH(WIDTH)) bus ();

    contador_descendente #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_out(input string tag, input int s, input int a, input int c);
        check({tag, ".salida"}, 32'(bus.salida), 32'(s));
        check({tag, ".activo"}, 32'(bus.activo), 32'(a));
        check({tag, ".cero"},   32'(bus.cero),   32'(c));
    endtask

    // Advance one rising edge and land 1 time unit after it, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic cnt, input logic ld,
                         input int d, input logic ar);
        bus.enable      = en;
        bus.count       = cnt;
        bus.load        = ld;
        bus.dato        = WIDTH'(d);
        bus.auto_reload = ar;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Reset applies without a clock edge.
        #1 rst_n = 1'b0;
        #2 check_out("reset_async", 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_out("reset_idle", 0, 0, 0);

        // Basic countdown 3,2,1,0 then IDLE.
        drive(1'b1, 1'b0, 1'b1, 3, 1'b0);
        step();
        check_out("basic_load", 3, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 3, 1'b0);
        step(); check_out("basic_2", 2, 1, 0);
        step(); check_out("basic_1", 1, 1, 0);
        step(); check_out("basic_0", 0, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(); check_out("basic_idle_a", 0, 0, 0);
        step(); check_out("basic_idle_b", 0, 0, 0);

        // Auto-reload: load wins over the simultaneous count.
        drive(1'b1, 1'b1, 1'b1, 2, 1'b1);
        step(); check_out("ar_load", 2, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b1);
        step(); check_out("ar_1a", 1, 1, 0);
        step(); check_out("ar_0a", 0, 0, 1);
        step(); check_out("ar_rel_a", 2, 1, 0);
        step(); check_out("ar_1b", 1, 1, 0);
        step(); check_out("ar_0b", 0, 0, 1);
        step(); check_out("ar_rel_b", 2, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(); check_out("ar_off_1", 1, 1, 0);
        step(); check_out("ar_off_0", 0, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(); check_out("ar_off_idle", 0, 0, 0);

        // Freeze with enable low, even with count and load asserted.
        drive(1'b1, 1'b0, 1'b1, 5, 1'b0);
        step(); check_out("frz_load", 5, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(); check_out("frz_4", 4, 1, 0);
        step(); check_out("frz_3", 3, 1, 0);
        drive(1'b0, 1'b1, 1'b1, 9, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("frz_hold%0d", i), 3, 1, 0);
        end
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(); check_out("frz_resume", 2, 1, 0);

        // Load priority over count while in RUN.
        drive(1'b1, 1'b0, 1'b1, 4, 1'b0);
        step(); check_out("prio_at4", 4, 1, 0);
        drive(1'b1, 1'b1, 1'b1, 9, 1'b0);
        step(); check_out("prio_load9", 9, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(); check_out("prio_8", 8, 1, 0);

        // DONE exit ignores enable; reload of 1 happens with enable low.
        drive(1'b1, 1'b0, 1'b1, 1, 1'b1);
        step(); check_out("done_en_load", 1, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b1);
        step(); check_out("done_en_0", 0, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
        step(); check_out("done_en_rel", 1, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(); check_out("done_en_0b", 0, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(); check_out("done_en_idle", 0, 0, 0);

        // Load in DONE preempts the exit; the pulse of that cycle is still seen.
        drive(1'b1, 1'b0, 1'b1, 1, 1'b0);
        step(); check_out("ldone_load1", 1, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(); check_out("ldone_0", 0, 0, 1);
        drive(1'b1, 1'b0, 1'b1, 6, 1'b0);
        step(); check_out("ldone_load6", 6, 1, 0);

        // Zero load goes straight to DONE and never reloads.
        drive(1'b1, 1'b0, 1'b1, 0, 1'b1);
        step(); check_out("zero_done", 0, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
        step(); check_out("zero_idle_a", 0, 0, 0);
        step(); check_out("zero_idle_b", 0, 0, 0);

        // Full range: 15 down to 0 without wrapping.
        drive(1'b1, 1'b0, 1'b1, 15, 1'b0);
        step(); check_out("full_load", 15, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 14; i >= 1; i--) begin
            step();
            check_out($sformatf("full_%0d", i), i, 1, 0);
        end
        step(); check_out("full_0", 0, 0, 1);
        step(); check_out("full_idle", 0, 0, 0);
        step();
`ifdef CONTADOR_DESCENDENTE_WRAP_EN
        check_out("idle_count", 15, 1, 0);
        step(); check_out("wrap_14", 14, 1, 0);
`else
        check_out("idle_count", 0, 0, 0);
`endif

        // Async reset in the middle of RUN: no cero pulse.
        drive(1'b1, 1'b0, 1'b1, 7, 1'b0);
        step(); check_out("rst_load7", 7, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(); check_out("rst_6", 6, 1, 0);
        step(); check_out("rst_5", 5, 1, 0);
        step(); check_out("rst_4", 4, 1, 0);
        #2 rst_n = 1'b0;
        #1 check_out("rst_mid", 0, 0, 0);
        step(); check_out("rst_held", 0, 0, 0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(); check_out("rst_after", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
